// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes, datapath width and execute-controller state encoding.
package alu_pkg;
    localparam int DW = 16;
    localparam logic [3:0] ALUC_PASS_A = 4'b0000;
    localparam logic [3:0] ALUC_PASS_B = 4'b0001;
    localparam logic [3:0] ALUC_NOT_A  = 4'b0010;
    localparam logic [3:0] ALUC_NOT_B  = 4'b0011;
    localparam logic [3:0] ALUC_ADD    = 4'b0100;
    localparam logic [3:0] ALUC_ADC    = 4'b0101;
    localparam logic [3:0] ALUC_OR     = 4'b0110;
    localparam logic [3:0] ALUC_AND    = 4'b0111;
    localparam logic [3:0] ALUC_XOR    = 4'b1000;
    localparam logic [3:0] ALUC_SHL    = 4'b1001;
    localparam logic [3:0] ALUC_SHR    = 4'b1010;
    localparam logic [3:0] ALUC_CLR_CY = 4'b1011;
    localparam logic [3:0] ALUC_SET_CY = 4'b1100;
    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;
    function automatic logic writes_reg(input logic [3:0] c);
        return c <= ALUC_SHR;
    endfunction
    function automatic logic writes_cy(input logic [3:0] c);
        return c == ALUC_ADD || c == ALUC_ADC;
    endfunction
    function automatic logic is_illegal(input logic [3:0] c);
        return c > ALUC_SET_CY;
    endfunction
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: operation handshake from the decode/sequencer to the execute controller.
interface alu_exec_ctrl_if #(parameter int AW = 3);
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_aluc;
    logic [AW-1:0] op_ra;
    logic [AW-1:0] op_rb;
    logic [AW-1:0] op_rd;
    logic          op_wr_en;
    modport master (output op_valid, op_aluc, op_ra, op_rb, op_rd, op_wr_en, input op_ready);
    modport slave (input op_valid, op_aluc, op_ra, op_rb, op_rd, op_wr_en, output op_ready);
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW register file, two operand read ports, one debug read port, one write port.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] ra_i,
    input  logic [AW-1:0] rb_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o,
    output logic [DW-1:0] dbg_data_o
);
    logic [DW-1:0] regs_q [NREG];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else if (we_i) regs_q[waddr_i] <= wdata_i;
    end
    assign rdata_a_o  = regs_q[ra_i];
    assign rdata_b_o  = regs_q[rb_i];
    assign dbg_data_o = regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller; registers ALU operands on accept, writes back z/carry one cycle later.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_ctrl_if.slave op_if,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [3:0]    alu_aluc_o,
    output logic          alu_cy_in_o,
    input  logic [DW-1:0] alu_z_i,
    input  logic          alu_cy_i,
    output logic          done_o,
    output logic          err_o,
    output logic          carry_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);
    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, rdata_a, rdata_b;
    logic [3:0]    aluc_q, aluc_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          cy_in_q, cy_in_d, wr_en_q, wr_en_d, carry_q, carry_d;
    logic          done_q, done_d, err_q, err_d, accept, wb, we;
    alu_regfile #(.NREG(NREG), .AW(AW)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (we),
        .waddr_i    (rd_q),
        .wdata_i    (alu_z_i),
        .ra_i       (op_if.op_ra),
        .rb_i       (op_if.op_rb),
        .dbg_addr_i (dbg_addr_i),
        .rdata_a_o  (rdata_a),
        .rdata_b_o  (rdata_b),
        .dbg_data_o (dbg_data_o)
    );
    assign op_if.op_ready = state_q == IDLE;
    // Writeback happens on the edge that closes EXEC; done/err then show for one cycle.
    always_comb begin
        accept  = op_if.op_valid && state_q == IDLE;
        wb      = state_q == EXEC;
        state_d = accept ? EXEC : IDLE;
        a_d     = accept ? rdata_a : a_q;
        b_d     = accept ? rdata_b : b_q;
        aluc_d  = accept ? op_if.op_aluc : aluc_q;
        cy_in_d = accept ? carry_q : cy_in_q;
        rd_d    = accept ? op_if.op_rd : rd_q;
        wr_en_d = accept ? op_if.op_wr_en : wr_en_q;
        we      = wb && wr_en_q && writes_reg(aluc_q);
        carry_d = !wb ? carry_q :
                  writes_cy(aluc_q) ? alu_cy_i :
                  aluc_q == ALUC_CLR_CY ? 1'b0 :
                  aluc_q == ALUC_SET_CY ? 1'b1 : carry_q;
        done_d  = wb;
        err_d   = wb && is_illegal(aluc_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            aluc_q  <= '0;
            cy_in_q <= 1'b0;
            rd_q    <= '0;
            wr_en_q <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aluc_q  <= aluc_d;
            cy_in_q <= cy_in_d;
            rd_q    <= rd_d;
            wr_en_q <= wr_en_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_aluc_o  = aluc_q;
    assign alu_cy_in_o = cy_in_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign carry_o     = carry_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: drives the execute controller with a combinational ALU and compares against a register-file model.
module tb_alu_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alu_a, alu_b, alu_z, dbg_data;
    logic [3:0]  alu_aluc;
    logic        alu_cy_in, alu_cy, done, err, carry;
    logic [2:0]  dbg_addr;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_reg [8];
    logic        m_cy;
    alu_exec_ctrl_if #(.AW(3)) op_if ();
    alu_exec_ctrl #(.NREG(8), .AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_if       (op_if),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_aluc_o  (alu_aluc),
        .alu_cy_in_o (alu_cy_in),
        .alu_z_i     (alu_z),
        .alu_cy_i    (alu_cy),
        .done_o      (done),
        .err_o       (err),
        .carry_o     (carry),
        .dbg_addr_i  (dbg_addr),
        .dbg_data_o  (dbg_data)
    );
    always #5 clk = ~clk;
    // The ALU the controller drives; z is zero for the carry-only and illegal codes.
    always_comb begin
        alu_z  = '0;
        alu_cy = 1'b0;
        case (alu_aluc)
            4'd0:  alu_z = alu_a;
            4'd1:  alu_z = alu_b;
            4'd2:  alu_z = ~alu_a;
            4'd3:  alu_z = ~alu_b;
            4'd4:  {alu_cy, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd5:  {alu_cy, alu_z} = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cy_in};
            4'd6:  alu_z = alu_a | alu_b;
            4'd7:  alu_z = alu_a & alu_b;
            4'd8:  alu_z = alu_a ^ alu_b;
            4'd9:  alu_z = alu_a << 1;
            4'd10: alu_z = alu_a >> 1;
            default: ;
        endcase
    end
    function automatic logic [16:0] ref_alu(input logic [3:0] c, input int a, input int b, input int cin);
        int r;
        case (c)
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = 65535 - a;
            4'd3:  r = 65535 - b;
            4'd4:  r = a + b;
            4'd5:  r = a + b + cin;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = a ^ b;
            4'd9:  r = (a * 2) % 65536;
            4'd10: r = a / 2;
            default: r = 0;
        endcase
        return 17'(r);
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_cy = 1'b0;
    endtask
    task automatic do_op(input logic [3:0] c, input int ra, input int rb, input int rd, input logic w);
        int n = 0;
        logic [16:0] res;
        logic exp_err;
        @(negedge clk);
        op_if.op_aluc  = c;
        op_if.op_ra    = 3'(ra);
        op_if.op_rb    = 3'(rb);
        op_if.op_rd    = 3'(rd);
        op_if.op_wr_en = w;
        op_if.op_valid = 1'b1;
        while (op_if.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (op_if.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout ready=%b required 1", op_if.op_ready);
            op_if.op_valid = 1'b0;
            return;
        end
        @(negedge clk);
        op_if.op_valid = 1'b0;
        dbg_addr = 3'(rd);
        #1;
        checks++;
        if (alu_a !== m_reg[ra] || alu_b !== m_reg[rb] || alu_aluc !== c || alu_cy_in !== m_cy) begin
            errors++;
            $display("FAIL operands a=%h b=%h aluc=%h cyin=%b required %h %h %h %b",
                     alu_a, alu_b, alu_aluc, alu_cy_in, m_reg[ra], m_reg[rb], c, m_cy);
        end
        checks++;
        if (op_if.op_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL exec_cycle ready=%b done=%b err=%b required 0 0 0", op_if.op_ready, done, err);
        end
        checks++;
        if (dbg_data !== m_reg[rd]) begin
            errors++;
            $display("FAIL dbg_old r%0d=%h required %h", rd, dbg_data, m_reg[rd]);
        end
        res     = ref_alu(c, int'(m_reg[ra]), int'(m_reg[rb]), int'(m_cy));
        exp_err = c >= 4'd13;
        if (c == 4'd11) m_cy = 1'b0;
        else if (c == 4'd12) m_cy = 1'b1;
        else if (c == 4'd4 || c == 4'd5) m_cy = res[16];
        if (w && c <= 4'd10) m_reg[rd] = res[15:0];
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== exp_err) begin
            errors++;
            $display("FAIL done_err aluc=%h done=%b err=%b required 1 %b", c, done, err, exp_err);
        end
        checks++;
        if (dbg_data !== m_reg[rd] || carry !== m_cy) begin
            errors++;
            $display("FAIL writeback aluc=%h r%0d=%h carry=%b required %h %b", c, rd, dbg_data, carry, m_reg[rd], m_cy);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        op_if.op_valid = 1'b0;
        op_if.op_aluc = '0;
        op_if.op_ra = '0;
        op_if.op_rb = '0;
        op_if.op_rd = '0;
        op_if.op_wr_en = 1'b0;
        dbg_addr = '0;
        model_reset();
        #12;
        checks++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_aluc !== 4'h0 || alu_cy_in !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || carry !== 1'b0 || op_if.op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs a=%h b=%h aluc=%h cyin=%b done=%b err=%b carry=%b ready=%b required zeros and ready=1",
                     alu_a, alu_b, alu_aluc, alu_cy_in, done, err, carry, op_if.op_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_preload();
        do_op(4'b1100, 0, 0, 0, 1'b0);
        do_op(4'b0101, 0, 0, 2, 1'b1);
        do_op(4'b0010, 0, 0, 1, 1'b1);
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'hFFFF) begin
            errors++;
            $display("FAIL preload_r1 got %h required ffff", dbg_data);
        end
        dbg_addr = 3'd2;
        #1;
        checks++;
        if (dbg_data !== 16'h0001) begin
            errors++;
            $display("FAIL preload_r2 got %h required 0001", dbg_data);
        end
    endtask
    task automatic test_add();
        do_op(4'b0100, 1, 2, 3, 1'b1);
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 16'h0000 || carry !== 1'b1) begin
            errors++;
            $display("FAIL add r3=%h carry=%b required 0000 1", dbg_data, carry);
        end
    endtask
    task automatic test_adc();
        do_op(4'b0101, 3, 2, 4, 1'b1);
        dbg_addr = 3'd4;
        #1;
        checks++;
        if (dbg_data !== 16'h0002 || carry !== 1'b0) begin
            errors++;
            $display("FAIL adc r4=%h carry=%b required 0002 0", dbg_data, carry);
        end
    endtask
    task automatic test_setcy_not();
        do_op(4'b1100, 0, 0, 5, 1'b1);
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 16'h0000 || carry !== 1'b1) begin
            errors++;
            $display("FAIL set_cy r5=%h carry=%b required 0000 1", dbg_data, carry);
        end
        do_op(4'b0010, 5, 0, 6, 1'b1);
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 16'hFFFF || carry !== 1'b1) begin
            errors++;
            $display("FAIL not_a r6=%h carry=%b required ffff 1", dbg_data, carry);
        end
    endtask
    task automatic test_illegal();
        do_op(4'b1110, 2, 2, 1, 1'b1);
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 16'hFFFF || carry !== 1'b1) begin
            errors++;
            $display("FAIL illegal r1=%h carry=%b required ffff 1", dbg_data, carry);
        end
    endtask
    task automatic test_back_to_back();
        int acc = 0;
        int dn = 0;
        @(negedge clk);
        op_if.op_aluc  = 4'b0110;
        op_if.op_ra    = 3'd1;
        op_if.op_rb    = 3'd1;
        op_if.op_rd    = 3'd1;
        op_if.op_wr_en = 1'b1;
        op_if.op_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (op_if.op_ready !== 1'(i % 2 == 0)) begin
                errors++;
                $display("FAIL ready_toggle cycle %0d ready=%b required %b", i, op_if.op_ready, 1'(i % 2 == 0));
            end
            if (op_if.op_ready === 1'b1) acc++;
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        op_if.op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        checks++;
        if (acc != 5 || dn != 5) begin
            errors++;
            $display("FAIL accept_count accepts=%0d dones=%0d required 5 5", acc, dn);
        end
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== m_reg[1] || carry !== m_cy) begin
            errors++;
            $display("FAIL or_self r1=%h carry=%b required %h %b", dbg_data, carry, m_reg[1], m_cy);
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_op(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask
    task automatic test_reset_mid_exec();
        int dn = 0;
        do_op(4'b0100, 1, 1, 7, 1'b1);
        do_op(4'b0001, 1, 1, 7, 1'b1);
        @(negedge clk);
        op_if.op_aluc  = 4'b0100;
        op_if.op_ra    = 3'd7;
        op_if.op_rb    = 3'd7;
        op_if.op_rd    = 3'd0;
        op_if.op_wr_en = 1'b1;
        op_if.op_valid = 1'b1;
        @(negedge clk);
        op_if.op_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_aluc !== 4'h0 || alu_cy_in !== 1'b0 ||
            carry !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset a=%h b=%h aluc=%h cyin=%b carry=%b done=%b err=%b required zeros",
                     alu_a, alu_b, alu_aluc, alu_cy_in, carry, done, err);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== 16'h0) begin
                errors++;
                $display("FAIL mid_reset_reg r%0d=%h required 0000", i, dbg_data);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0) dn++;
            @(negedge clk);
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL mid_reset_done pulses=%0d required 0", dn);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_preload();
        test_add();
        test_adc();
        test_setcy_not();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
